// File: rtl/wb_result_stage.sv
// wb_result_stage: MEM/WB pipeline register and writeback result selector.
// Captures NUM_SRC candidate results from the M stage, picks one in W,
// applies load byte/halfword extension, qualifies the register write and
// counts instructions retiring out of W.
module wb_result_stage #(
    parameter int WIDTH    = 32,
    parameter int NUM_SRC  = 3,
    parameter int SEL_W    = 2,
    parameter int LOAD_IDX = 1,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_w,
    input  logic                     flush_w,
    input  logic                     valid_m,
    input  logic                     regwrite_m,
    input  logic [4:0]               a3_m,
    input  logic [SEL_W-1:0]         sel_m,
    input  logic [NUM_SRC*WIDTH-1:0] src_m,
    input  logic [2:0]               ldext_m,
    input  logic [1:0]               byteoff_m,
    output logic                     valid_w,
    output logic                     regwrite_w,
    output logic [4:0]               a3_w,
    output logic [WIDTH-1:0]         result_w,
    output logic [CNT_W-1:0]         retire_cnt
);

    // Load type encoding carried from the M stage.
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BU = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_H  = 3'b100
    } ldext_e;

    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_IDX);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Control registers: cleared by reset and by flush.
    logic               valid_q,    valid_d;
    logic               regwrite_q, regwrite_d;
    logic [4:0]         a3_q,       a3_d;
    logic [SEL_W-1:0]   sel_q,      sel_d;
    logic [2:0]         ldext_q,    ldext_d;
    logic [1:0]         byteoff_q,  byteoff_d;

    // Data register: only the bubble's valid bit matters, so flush lets it hold.
    logic [NUM_SRC*WIDTH-1:0] src_q, src_d;

    // Retired-instruction counter.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Datapath intermediates for the result selector.
    logic [WIDTH-1:0] selected;
    logic [WIDTH-1:0] byteShifted;
    logic [WIDTH-1:0] halfShifted;
    logic [7:0]       loadByte;
    logic [15:0]      loadHalf;
    logic [WIDTH-1:0] extended;

    // Next-state for control fields: flush beats stall, stall beats capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        a3_d       = a3_q;
        sel_d      = sel_q;
        ldext_d    = ldext_q;
        byteoff_d  = byteoff_q;
        if (flush_w) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            a3_d       = 5'd0;
            sel_d      = '0;
            ldext_d    = 3'b000;
            byteoff_d  = 2'b00;
        end else if (!stall_w) begin
            valid_d    = valid_m;
            regwrite_d = regwrite_m;
            a3_d       = a3_m;
            sel_d      = sel_m;
            ldext_d    = ldext_m;
            byteoff_d  = byteoff_m;
        end
    end

    // Next-state for the captured source words: only a normal advance loads them.
    always_comb begin
        src_d = src_q;
        if (!flush_w && !stall_w) begin
            src_d = src_m;
        end
    end

    // Next-state for the retire counter: the instruction in W leaves unless stalled.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stall_w) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // W-stage register bank with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            a3_q       <= 5'd0;
            sel_q      <= '0;
            ldext_q    <= 3'b000;
            byteoff_q  <= 2'b00;
            src_q      <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            a3_q       <= a3_d;
            sel_q      <= sel_d;
            ldext_q    <= ldext_d;
            byteoff_q  <= byteoff_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

    // Source mux: out-of-range selects fall back to source 0.
    always_comb begin
        selected = src_q[0 +: WIDTH];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                selected = src_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Align the addressed byte and halfword to bit 0; halfwords ignore byteoff[0].
    always_comb begin
        byteShifted = selected >> {byteoff_q, 3'b000};
        halfShifted = selected >> {byteoff_q[1], 4'b0000};
        loadByte    = byteShifted[7:0];
        loadHalf    = halfShifted[15:0];
    end

    // Load extension applies only when the load source is selected.
    always_comb begin
        extended = selected;
        if (sel_q == LOAD_SEL) begin
            case (ldext_q)
                LD_BU:   extended = {{(WIDTH-8){1'b0}}, loadByte};
                LD_B:    extended = {{(WIDTH-8){loadByte[7]}}, loadByte};
                LD_HU:   extended = {{(WIDTH-16){1'b0}}, loadHalf};
                LD_H:    extended = {{(WIDTH-16){loadHalf[15]}}, loadHalf};
                default: extended = selected;
            endcase
        end
    end

    // Outputs come only from W registers; bubbles read as zero and never write $0.
    always_comb begin
        valid_w    = valid_q;
        regwrite_w = valid_q & regwrite_q & (a3_q != 5'd0);
        a3_w       = a3_q;
        result_w   = valid_q ? extended : '0;
        retire_cnt = cnt_q;
    end

endmodule

// File: tb/tb_wb_result_stage.sv
// Self-checking bench for wb_result_stage with a behavioural reference model.
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_w;
    logic        flush_w;
    logic        valid_m;
    logic        regwrite_m;
    logic [4:0]  a3_m;
    logic [1:0]  sel_m;
    logic [95:0] src_m;
    logic [2:0]  ldext_m;
    logic [1:0]  byteoff_m;

    logic        valid_w;
    logic        regwrite_w;
    logic [4:0]  a3_w;
    logic [31:0] result_w;
    logic [31:0] retire_cnt;

    logic        valid_ws;
    logic        regwrite_ws;
    logic [4:0]  a3_ws;
    logic [31:0] result_ws;
    logic [3:0]  retire_cnt_s;

    int checks = 0;
    int passes = 0;

    // Reference model state: what W should hold after each edge.
    bit          mValid;
    bit          mRegw;
    bit [4:0]    mA3;
    bit [1:0]    mSel;
    bit [2:0]    mLd;
    bit [1:0]    mOff;
    bit [31:0]   mSrc [3];
    bit [31:0]   mCnt;

    wb_result_stage dut (
        .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .a3_m(a3_m), .sel_m(sel_m),
        .src_m(src_m), .ldext_m(ldext_m), .byteoff_m(byteoff_m),
        .valid_w(valid_w), .regwrite_w(regwrite_w), .a3_w(a3_w),
        .result_w(result_w), .retire_cnt(retire_cnt)
    );

    wb_result_stage #(.CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .a3_m(a3_m), .sel_m(sel_m),
        .src_m(src_m), .ldext_m(ldext_m), .byteoff_m(byteoff_m),
        .valid_w(valid_ws), .regwrite_w(regwrite_ws), .a3_w(a3_ws),
        .result_w(result_ws), .retire_cnt(retire_cnt_s)
    );

    always #5 clk = ~clk;

    // Expected writeback value computed arithmetically from the load rules.
    function automatic bit [31:0] modelResult();
        bit [31:0] w;
        bit [31:0] by;
        bit [31:0] hw;
        if (!mValid) return 32'h0;
        w = (mSel < 2'd3) ? mSrc[mSel] : mSrc[0];
        if (mSel != 2'd1) return w;
        by = (w / (32'd1 << (8 * mOff))) % 32'd256;
        hw = (w / (32'd1 << (16 * (mOff / 2)))) % 32'd65536;
        case (mLd)
            3'd1:    return by;
            3'd2:    return (by >= 32'd128) ? (by + 32'hFFFFFF00) : by;
            3'd3:    return hw;
            3'd4:    return (hw >= 32'd32768) ? (hw + 32'hFFFF0000) : hw;
            default: return w;
        endcase
    endfunction

    function automatic bit modelRegw();
        return mValid && mRegw && (mA3 != 5'd0);
    endfunction

    // Advance the model by one clock edge using the inputs applied at that edge.
    task automatic modelEdge();
        if (reset) begin
            mValid = 0; mRegw = 0; mA3 = 0; mSel = 0; mLd = 0; mOff = 0;
            for (int i = 0; i < 3; i++) mSrc[i] = 0;
            mCnt = 0;
        end else begin
            if (mValid && !stall_w) mCnt = mCnt + 1;
            if (flush_w) begin
                mValid = 0; mRegw = 0; mA3 = 0; mSel = 0; mLd = 0; mOff = 0;
            end else if (!stall_w) begin
                mValid = valid_m; mRegw = regwrite_m; mA3 = a3_m;
                mSel = sel_m; mLd = ldext_m; mOff = byteoff_m;
                for (int i = 0; i < 3; i++) mSrc[i] = src_m[i*32 +: 32];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus();
        valid_m    = 1'($urandom_range(0, 3) != 0);
        regwrite_m = 1'($urandom);
        a3_m       = 5'($urandom);
        sel_m      = 2'($urandom);
        src_m      = {$urandom, $urandom, $urandom};
        ldext_m    = 3'($urandom_range(0, 7));
        byteoff_m  = 2'($urandom);
    endtask

    task automatic test_reset();
        reset = 1; stall_w = 0; flush_w = 0;
        valid_m = 1; regwrite_m = 1; a3_m = 5'd5; sel_m = 2'd0; ldext_m = 3'd0; byteoff_m = 0;
        src_m = {32'h33333333, 32'h22222222, 32'hCAFEF00D};
        tick(); tick();
        checks++; if (valid_w !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", valid_w); else passes++;
        checks++; if (regwrite_w !== 1'b0) $display("[TB] FAIL reset_regwrite got %0b want 0", regwrite_w); else passes++;
        checks++; if (result_w !== 32'h0) $display("[TB] FAIL reset_result got %h want 0", result_w); else passes++;
        checks++; if (retire_cnt !== 32'h0) $display("[TB] FAIL reset_cnt got %0d want 0", retire_cnt); else passes++;
        checks++; if (a3_w !== 5'd0) $display("[TB] FAIL reset_a3 got %0d want 0", a3_w); else passes++;
        reset = 0;
        tick();
        checks++; if (valid_w !== 1'b1) $display("[TB] FAIL first_capture_valid got %0b want 1", valid_w); else passes++;
        checks++; if (result_w !== 32'hCAFEF00D) $display("[TB] FAIL first_capture_result got %h want cafef00d", result_w); else passes++;
        checks++; if (regwrite_w !== 1'b1 || a3_w !== 5'd5) $display("[TB] FAIL first_capture_dest got %0b/%0d want 1/5", regwrite_w, a3_w); else passes++;
    endtask

    task automatic test_source_select();
        bit [31:0] expTable [4];
        expTable[0] = 32'h11111111; expTable[1] = 32'h22222222;
        expTable[2] = 32'h33333333; expTable[3] = 32'h11111111;
        src_m = {32'h33333333, 32'h22222222, 32'h11111111};
        valid_m = 1; regwrite_m = 1; a3_m = 5'd7; ldext_m = 3'd0; byteoff_m = 2'd3;
        for (int i = 0; i < 4; i++) begin
            sel_m = 2'(i);
            tick();
            checks++;
            if (result_w !== expTable[i]) $display("[TB] FAIL select_%0d got %h want %h", i, result_w, expTable[i]);
            else passes++;
        end
        checks++; if (retire_cnt !== mCnt) $display("[TB] FAIL select_cnt got %0d want %0d", retire_cnt, mCnt); else passes++;
    endtask

    task automatic test_load_ext();
        bit [2:0]  ldTab  [6] = '{3'd2, 3'd2, 3'd1, 3'd4, 3'd3, 3'd4};
        bit [1:0]  offTab [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
        bit [31:0] expTab [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                                  32'hFFFF80FF, 32'h00007F01, 32'h00007F01};
        src_m = {32'h33333333, 32'h80FF7F01, 32'h11111111};
        valid_m = 1; regwrite_m = 1; a3_m = 5'd8; sel_m = 2'd1;
        for (int i = 0; i < 6; i++) begin
            ldext_m = ldTab[i]; byteoff_m = offTab[i];
            tick();
            checks++;
            if (result_w !== expTab[i]) $display("[TB] FAIL loadext_%0d got %h want %h", i, result_w, expTab[i]);
            else passes++;
        end
        sel_m = 2'd2; ldext_m = 3'd2; byteoff_m = 2'd1;
        tick();
        checks++; if (result_w !== 32'h33333333) $display("[TB] FAIL loadext_ignored got %h want 33333333", result_w); else passes++;
    endtask

    task automatic test_zero_and_flush();
        valid_m = 1; regwrite_m = 1; a3_m = 5'd0; sel_m = 2'd0; ldext_m = 0; byteoff_m = 0;
        src_m = {32'h3, 32'h2, 32'h1};
        tick();
        checks++; if (regwrite_w !== 1'b0) $display("[TB] FAIL zero_reg got %0b want 0", regwrite_w); else passes++;
        a3_m = 5'd9;
        tick();
        checks++; if (regwrite_w !== 1'b1) $display("[TB] FAIL nonzero_reg got %0b want 1", regwrite_w); else passes++;
        flush_w = 1;
        tick();
        checks++; if (valid_w !== 1'b0) $display("[TB] FAIL flush_valid got %0b want 0", valid_w); else passes++;
        checks++; if (result_w !== 32'h0) $display("[TB] FAIL flush_result got %h want 0", result_w); else passes++;
        checks++; if (retire_cnt !== mCnt) $display("[TB] FAIL flush_cnt got %0d want %0d", retire_cnt, mCnt); else passes++;
        flush_w = 0;
        tick();
        flush_w = 1; stall_w = 1;
        tick();
        checks++; if (valid_w !== 1'b0 || result_w !== 32'h0) $display("[TB] FAIL flush_stall got %0b/%h want 0/0", valid_w, result_w); else passes++;
        checks++; if (retire_cnt !== mCnt) $display("[TB] FAIL flush_stall_cnt got %0d want %0d", retire_cnt, mCnt); else passes++;
        flush_w = 0; stall_w = 0;
    endtask

    task automatic test_stall();
        bit [31:0] frozenRes;
        bit [31:0] frozenCnt;
        bit [4:0]  frozenA3;
        valid_m = 1; regwrite_m = 1; a3_m = 5'd12; sel_m = 2'd2; ldext_m = 0; byteoff_m = 0;
        src_m = {32'hABCD1234, 32'h2, 32'h1};
        tick();
        frozenRes = 32'hABCD1234; frozenA3 = 5'd12; frozenCnt = mCnt;
        stall_w = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            tick();
            checks++;
            if (result_w !== frozenRes || a3_w !== frozenA3 || valid_w !== 1'b1)
                $display("[TB] FAIL stall_hold_%0d got %h/%0d/%0b want %h/%0d/1", i, result_w, a3_w, valid_w, frozenRes, frozenA3);
            else passes++;
            checks++;
            if (retire_cnt !== frozenCnt) $display("[TB] FAIL stall_cnt_%0d got %0d want %0d", i, retire_cnt, frozenCnt);
            else passes++;
        end
        stall_w = 0; valid_m = 1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (retire_cnt !== frozenCnt + 32'(i)) $display("[TB] FAIL stall_resume_%0d got %0d want %0d", i, retire_cnt, frozenCnt + 32'(i));
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            applyStimulus();
            stall_w = 1'($urandom_range(0, 3) == 0);
            flush_w = 1'($urandom_range(0, 7) == 0);
            reset   = 1'($urandom_range(0, 31) == 0);
            tick();
            checks++;
            if (valid_w !== mValid || regwrite_w !== modelRegw() || a3_w !== mA3 ||
                result_w !== modelResult() || retire_cnt !== mCnt || retire_cnt_s !== 4'(mCnt))
                $display("[TB] FAIL random_%0d got v%0b w%0b a%0d r%h c%0d s%0d want v%0b w%0b a%0d r%h c%0d",
                         n, valid_w, regwrite_w, a3_w, result_w, retire_cnt, retire_cnt_s,
                         mValid, modelRegw(), mA3, modelResult(), mCnt);
            else passes++;
        end
        reset = 0; stall_w = 0; flush_w = 0;
    endtask

    task automatic test_counter_wrap();
        bit [3:0] wrapExp [3] = '{4'd15, 4'd0, 4'd1};
        reset = 1; stall_w = 0; flush_w = 0; valid_m = 1;
        tick();
        reset = 0; stall_w = 1; flush_w = 1;
        reset = 1; tick();
        reset = 0; stall_w = 0; flush_w = 0;
        checks++; if (retire_cnt_s !== 4'd0 || valid_ws !== 1'b0) $display("[TB] FAIL reset_mid_stall got %0d/%0b want 0/0", retire_cnt_s, valid_ws); else passes++;
        for (int k = 1; k <= 18; k++) begin
            tick();
            checks++;
            if (retire_cnt_s !== 4'((k - 1) % 16)) $display("[TB] FAIL wrap_step_%0d got %0d want %0d", k, retire_cnt_s, (k - 1) % 16);
            else passes++;
            if (k >= 16) begin
                checks++;
                if (retire_cnt_s !== wrapExp[k-16]) $display("[TB] FAIL wrap_point_%0d got %0d want %0d", k, retire_cnt_s, wrapExp[k-16]);
                else passes++;
            end
        end
        checks++; if (retire_cnt !== 32'd17) $display("[TB] FAIL wide_cnt got %0d want 17", retire_cnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_source_select();
        test_load_ext();
        test_zero_and_flush();
        test_stall();
        test_random();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
Parametrised MEM/WB pipeline register and writeback result selector for the five-stage MIPS core; the next generation of the fixed three-input W-stage result mux. It captures NUM_SRC candidate results from the M stage and selects one in W. It applies load byte/halfword extension, gates register write, and counts retired instructions. Its outputs feed the register file write port and the forwarding unit.

Parameters:
WIDTH, 32, datapath width in bits (multiple of 16)
NUM_SRC, 3, number of result sources (2..8); index 0 ALUOut, 1 DMOut, 2 pc4 by convention
SEL_W, 2, width of select field; must satisfy 2^SEL_W >= NUM_SRC
LOAD_IDX, 1, source index that receives load extension
CNT_W, 32, width of retire counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall_w  in  1  hold W register contents
flush_w  in  1  insert bubble into W
valid_m  in  1  M-stage instruction valid
regwrite_m  in  1  M-stage register write enable
a3_m  in  5  destination register number
sel_m  in  SEL_W  result source select (MemtoReg generalised)
src_m  in  NUM_SRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH]
ldext_m  in  3  load type: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh, others treated as lw
byteoff_m  in  2  load address bits [1:0]
valid_w  out  1  W instruction valid
regwrite_w  out  1  qualified register write enable
a3_w  out  5  registered destination
result_w  out  WIDTH  final writeback data
retire_cnt  out  CNT_W  count of retired valid instructions

Behaviour:
- Priority per rising edge: reset > flush_w > stall_w > normal capture.
- reset: all W registers clear. valid_w=0, regwrite_w=0, a3_w=0, result_w=0, retire_cnt=0.
- flush_w (no reset): W valid/regwrite/a3/sel/ldext/byteoff registers clear. Data registers may hold; result_w must read 0 while valid_w=0. retire_cnt still counts the instruction leaving W this edge.
- stall_w (no reset/flush): every W register holds. retire_cnt holds.
- Normal: all *_m inputs are captured. Outputs reflect them one cycle after the edge (latency 1). No combinational path from *_m to any output.
- regwrite_w = valid_w & regwrite_reg & (a3_w != 0). Writes to $0 are suppressed.
- result_w is combinational from the W registers only.
  - selected = src[sel]; sel >= NUM_SRC selects source 0.
  - If sel == LOAD_IDX, apply extension to the selected word w, using byteoff b:
    - lbu: zero-extend byte w[8b+7:8b]
    - lb: sign-extend the same byte
    - lhu: zero-extend half w[16h+15:16h], h = b[1]; b[0] is ignored
    - lh: sign-extend the same half
    - lw and reserved codes: w unchanged
  - If sel != LOAD_IDX, ldext is ignored.
  - result_w = 0 whenever valid_w=0.
- retire_cnt increments by 1 on each edge where valid_w=1 and stall_w=0 and reset=0. It wraps from all-ones to 0 with no saturation.
- Reset asserted mid-stall or mid-flush still clears everything on that edge.
- Widths are all WIDTH-bit. There is no overflow concern: extension never exceeds WIDTH.

Test Plan:
- Reset: hold reset 2 cycles with valid_m=1 and src_m nonzero -> valid_w=0, regwrite_w=0, result_w=0, retire_cnt=0. First edge after release captures inputs.
- Source select: sources 0x11111111 / 0x22222222 / 0x33333333. Step sel_m 0, 1, 2, 3 with ldext=lw -> result_w one cycle later is 0x11111111, 0x22222222, 0x33333333, then 0x11111111 (out of range).
- Load extension: sel=LOAD_IDX, DMOut=0x80FF7F01. Expected result_w:
  - lb, off 1 -> 0x0000007F
  - lb, off 2 -> 0xFFFFFFFF
  - lbu, off 3 -> 0x00000080
  - lh, off 2 -> 0xFFFF80FF
  - lhu, off 0 -> 0x00007F01
  - lh, off 1 -> 0x00007F01 (b[0] ignored)
- $0 and flush: regwrite_m=1, a3_m=0 -> regwrite_w=0. flush_w with a valid instruction in M -> next cycle valid_w=0, result_w=0. Asserting flush_w and stall_w together gives flush behaviour.
- Stall: stall_w held 3 cycles while *_m inputs change -> outputs frozen; retire_cnt unchanged for 3 cycles, then resumes +1 per valid instruction.
- Counter wrap: CNT_W=4, 17 valid instructions retire -> retire_cnt reads 15, then 0, then 1.
